// File: rtl/carrier_demod_cos.sv
// In-phase carrier demodulator: shift-add cosine multiply, 16-sample integrate-and-dump, Gray I slicer.
// Optional build macro DEMOD_COS_ERR_EN drives err on overrange dumps and resync discards.
module carrier_demod_cos #(
  parameter int WIDTH_SYM = 16,
  parameter int ACC_W     = 22,
  parameter int THR       = 16384
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic signed [WIDTH_SYM-1:0] sample_in,
  input  logic                        sample_valid,
  input  logic                        sym_start,
  output logic signed [ACC_W-1:0]     acc_out,
  output logic [1:0]                  i_level,
  output logic                        out_valid,
  output logic                        err
);

  typedef enum logic [2:0] {C_ONE, C_ZERO, C_924, C_707, C_383} coef_t;

  localparam logic signed [ACC_W-1:0] L_THR   = ACC_W'(THR);
  localparam logic signed [ACC_W-1:0] L_NTHR  = -L_THR;
  localparam logic signed [ACC_W-1:0] L_THR2  = ACC_W'(2 * THR);
  localparam logic signed [ACC_W-1:0] L_NTHR2 = -L_THR2;

  function automatic coef_t coef_class(input logic [3:0] p);
    case (p)
      4'd0, 4'd8:                 return C_ONE;
      4'd4, 4'd12:                return C_ZERO;
      4'd1, 4'd7, 4'd9, 4'd15:    return C_924;
      4'd2, 4'd6, 4'd10, 4'd14:   return C_707;
      default:                    return C_383;
    endcase
  endfunction

  logic [3:0]                  r_phase;
  logic signed [WIDTH_SYM:0]   r_prod;
  logic                        r_prod_valid;
  logic                        r_prod_last;
  logic                        r_prod_resync;
  logic signed [ACC_W-1:0]     r_acc;
  logic signed [ACC_W-1:0]     r_acc_out;
  logic [1:0]                  r_level;
  logic                        r_out_valid;

  logic [3:0]                  w_phase;
  logic [WIDTH_SYM-1:0]        w_mag;
  logic [WIDTH_SYM:0]          w_m;
  logic [WIDTH_SYM:0]          w_mag_prod;
  logic                        w_neg;
  logic signed [WIDTH_SYM:0]   w_prod;
  logic signed [ACC_W-1:0]     w_prod_ext;
  logic signed [ACC_W-1:0]     w_sum;
  logic [1:0]                  w_level;

  // Shifts act on the unsigned magnitude so truncation is symmetric for +/- samples.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    w_phase    = sym_start ? 4'd0 : r_phase;
    w_mag      = sample_in[WIDTH_SYM-1] ? WIDTH_SYM'(-sample_in) : WIDTH_SYM'(sample_in);
    w_m        = {1'b0, w_mag};
    w_mag_prod = '0;
    case (coef_class(w_phase))
      C_ONE:  w_mag_prod = w_m;
      C_924:  w_mag_prod = (w_m >> 1) + (w_m >> 2) + (w_m >> 3) + (w_m >> 5)
                         + (w_m >> 6) + (w_m >> 9);
      C_707:  w_mag_prod = (w_m >> 1) + (w_m >> 3) + (w_m >> 4) + (w_m >> 6)
                         + (w_m >> 8);
      C_383:  w_mag_prod = (w_m >> 2) + (w_m >> 3) + (w_m >> 8) + (w_m >> 9)
                         + (w_m >> 10) + (w_m >> 11) + (w_m >> 12);
      default: w_mag_prod = '0;
    endcase
    w_neg  = sample_in[WIDTH_SYM-1] ^ ((w_phase >= 4'd5) && (w_phase <= 4'd11));
    w_prod = w_neg ? -$signed(w_mag_prod) : $signed(w_mag_prod);
  end

  always_comb begin
    w_prod_ext = {{(ACC_W-WIDTH_SYM-1){r_prod[WIDTH_SYM]}}, r_prod};
    w_sum      = r_acc + w_prod_ext;
    if (w_sum < L_NTHR)      w_level = 2'b00;
    else if (w_sum < 0)      w_level = 2'b01;
    else if (w_sum < L_THR)  w_level = 2'b11;
    else                     w_level = 2'b10;
  end

  // Stage 1: accept sample, advance phase, register product.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase       <= '0;
      r_prod        <= '0;
      r_prod_valid  <= 1'b0;
      r_prod_last   <= 1'b0;
      r_prod_resync <= 1'b0;
    end else begin
      r_prod_valid <= sample_valid;
      if (sample_valid) begin
        r_phase       <= w_phase + 4'd1;
        r_prod        <= w_prod;
        r_prod_last   <= (w_phase == 4'd15);
        r_prod_resync <= sym_start && (r_phase != 4'd0);
      end
    end
  end

  // Stage 2: accumulate; dump on phase 15, restart on a resync product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_acc_out   <= '0;
      r_level     <= 2'b00;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (r_prod_valid) begin
        if (r_prod_resync) begin
          r_acc <= w_prod_ext;
        end else if (r_prod_last) begin
          r_acc       <= '0;
          r_acc_out   <= w_sum;
          r_level     <= w_level;
          r_out_valid <= 1'b1;
        end else begin
          r_acc <= w_sum;
        end
      end
    end
  end

`ifdef DEMOD_COS_ERR_EN
  logic r_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= r_prod_valid &&
                         (r_prod_resync ||
                          (r_prod_last && ((w_sum >= L_THR2) || (w_sum <= L_NTHR2))));
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign acc_out   = r_acc_out;
  assign i_level   = r_level;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_carrier_demod_cos.sv
// Directed bench for carrier_demod_cos: cosine symbols at several amplitudes, gaps, resync, reset.
module tb_carrier_demod_cos;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic signed [15:0]  sample_in = '0;
  logic                sample_valid = 1'b0;
  logic                sym_start = 1'b0;
  logic signed [21:0]  acc_out;
  logic [1:0]          i_level;
  logic                out_valid;
  logic                err;

  carrier_demod_cos dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sym_start    (sym_start),
    .acc_out      (acc_out),
    .i_level      (i_level),
    .out_valid    (out_valid),
    .err          (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_edge = 0;
  int errcnt = 0;
  int q_acc[$];
  int q_lvl[$];
  int q_cyc[$];

  // A = 1024 cosine table, rounded to integers
  int cos1024[16] = '{1024, 946, 724, 392, 0, -392, -724, -946,
                      -1024, -946, -724, -392, 0, 392, 724, 946};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      q_acc.push_back(int'(acc_out));
      q_lvl.push_back(int'(i_level));
      q_cyc.push_back(cyc);
    end
    if (err === 1'b1) errcnt = errcnt + 1;
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int s, input bit st);
    sample_in    = 16'(s);
    sample_valid = 1'b1;
    sym_start    = st;
    @(posedge clk);
    #1;
    last_edge    = cyc;
    sample_valid = 1'b0;
    sym_start    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input int scale, input bit st0, output int e0);
    e0 = 0;
    for (int k = 0; k < 16; k++) begin
      send(scale * cos1024[k], st0 && (k == 0));
      if (k == 0) e0 = last_edge;
    end
  endtask

  task automatic wait_results(input int n, input string tag);
    int t;
    t = 0;
    while (q_acc.size() < n && t < 64) begin
      @(posedge clk);
      #1;
      t++;
    end
    idle(3);
    check(tag, q_acc.size(), n);
  endtask

  initial begin
    int idx, e0, e1, e2, e3, err0, exp_err;

    // Reset state
    idle(3);
    check("rst_acc_out", acc_out, 0);
    check("rst_i_level", i_level, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    idle(2);

    // A=1024 single symbol: 8164
    idx = q_acc.size();
    send_sym(1, 1'b1, e0);
    wait_results(idx + 1, "a1024_count");
    check("a1024_acc", q_acc[idx], 8164);
    check("a1024_lvl", q_lvl[idx], 3);
    check("a1024_latency", q_cyc[idx], e0 + 16);

    // Back-to-back +3072, -1024, -3072, then +1024 closing the run
    idx = q_acc.size();
    send_sym(3, 1'b1, e0);
    send_sym(-1, 1'b1, e1);
    send_sym(-3, 1'b1, e2);
    send_sym(1, 1'b1, e3);
    wait_results(idx + 4, "b2b_count");
    check("b2b_acc_p3072", q_acc[idx], 24544);
    check("b2b_lvl_p3072", q_lvl[idx], 2);
    check("b2b_acc_m1024", q_acc[idx+1], -8164);
    check("b2b_lvl_m1024", q_lvl[idx+1], 1);
    check("b2b_acc_m3072", q_acc[idx+2], -24544);
    check("b2b_lvl_m3072", q_lvl[idx+2], 0);
    check("b2b_acc_p1024", q_acc[idx+3], 8164);
    check("b2b_spacing1", q_cyc[idx+1] - q_cyc[idx], 16);
    check("b2b_spacing2", q_cyc[idx+2] - q_cyc[idx+1], 16);
    check("b2b_spacing3", q_cyc[idx+3] - q_cyc[idx+2], 16);

    // Constant 1000 integrates to exactly zero
    idx = q_acc.size();
    for (int k = 0; k < 16; k++) send(1000, k == 0);
    wait_results(idx + 1, "const_count");
    check("const_acc", q_acc[idx], 0);
    check("const_lvl", q_lvl[idx], 3);

    // A=1024 with three single-cycle gaps: same sum, 3 cycles later
    idx = q_acc.size();
    e0 = 0;
    for (int k = 0; k < 16; k++) begin
      send(cos1024[k], k == 0);
      if (k == 0) e0 = last_edge;
      if (k == 3 || k == 8 || k == 13) idle(1);
    end
    wait_results(idx + 1, "gap_count");
    check("gap_acc", q_acc[idx], 8164);
    check("gap_latency", q_cyc[idx], e0 + 19);

    // Resync at phase 7, then a full A=-1024 symbol
    idx  = q_acc.size();
    err0 = errcnt;
    for (int k = 0; k < 7; k++) send(cos1024[k], k == 0);
    send_sym(-1, 1'b1, e0);
    wait_results(idx + 1, "resync_count");
    check("resync_acc", q_acc[idx], -8164);
    check("resync_lvl", q_lvl[idx], 1);
    check("resync_latency", q_cyc[idx], e0 + 16);
`ifdef DEMOD_COS_ERR_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    check("resync_err", errcnt - err0, exp_err);

    // Reset at phase 9 of an A=3072 symbol
    idx = q_acc.size();
    for (int k = 0; k < 9; k++) send(3 * cos1024[k], k == 0);
    rst_n = 1'b0;
    #1;
    check("midrst_acc_out", acc_out, 0);
    check("midrst_i_level", i_level, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_err", err, 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    check("midrst_no_output", q_acc.size(), idx);
    for (int k = 0; k < 16; k++) send(3 * cos1024[k], 1'b0);
    wait_results(idx + 1, "postrst_count");
    check("postrst_acc", q_acc[idx], 24544);
    check("postrst_lvl", q_lvl[idx], 2);

    // Outputs hold between pulses
    idle(5);
    check("hold_acc_out", acc_out, 24544);
    check("hold_out_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/carrier_demod_cos.md
# carrier_demod_cos

Receive-side in-phase carrier demodulator for the QAM-16 link. It multiplies each received passband sample by the 16-phase cosine carrier, using the same shift-add coefficients as the transmit carrier multiplier. It integrates the products over one 16-sample symbol, then dumps the sum and slices it into a 2-bit Gray-coded I level. It sits between the receive sample source and the symbol demapper, in parallel with the sine (Q) branch.

## Interface
- WIDTH_SYM, 16, sample width (signed two's complement)
- ACC_W, 22, accumulator/dump width
- THR, 16384, decision threshold in accumulator units (nominal ±1 level at 1024 integrates to about 8192)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- sample_in  in  WIDTH_SYM  signed received sample
- sample_valid  in  1  sample_in is valid this cycle
- sym_start  in  1  with sample_valid: this sample is phase 0 of a new symbol
- acc_out  out  ACC_W  signed integrated correlation of the last symbol
- i_level  out  2  Gray I decision: 00=-3, 01=-1, 11=+1, 10=+3
- out_valid  out  1  one-cycle pulse, acc_out and i_level are new
- err  out  1  one-cycle error pulse (see Configuration)

## Operation
- Phase counter, 4 bits:
  - Increments on each accepted sample (sample_valid=1) and wraps 15→0.
  - A sample accepted with sym_start=1 is forced to phase 0, and the counter goes to 1.
- Coefficient magnitudes (|x| = magnitude of sample, `>>` logical on the magnitude):
  - Phase 0, 8: c=1.0, i.e. |x|.
  - Phase 4, 12: c=0, i.e. 0.
  - Phases 1, 7, 9, 15: c≈0.924, i.e. |x|>>1 + >>2 + >>3 + >>5 + >>6 + >>9.
  - Phases 2, 6, 10, 14: c≈0.707, i.e. >>1 + >>3 + >>4 + >>6 + >>8.
  - Phases 3, 5, 11, 13: c≈0.383, i.e. >>2 + >>3 + >>8 + >>9 + >>10 + >>11 + >>12.
- Coefficient sign: positive for phases 0–3 and 13–15, negative for phases 5–11.
- Product:
  - |x| is an unsigned WIDTH_SYM-bit magnitude, so -32768 gives 32768 with no wrap.
  - The product is signed WIDTH_SYM+1 bits, negated when (sample sign XOR coefficient sign)=1.
  - Truncation of shifted terms happens on the magnitude, so products are exactly odd-symmetric in phase.
- Accumulator, signed ACC_W bits:
  - Adds each registered product.
  - On the product of phase 15, dumps acc+product to acc_out, clears acc to 0, and pulses out_valid.
  - No overflow is possible at the default widths (16 × 2^16 < 2^21).
- Slicer, applied to the dumped value s:
  - s < -THR → 00
  - -THR ≤ s < 0 → 01
  - 0 ≤ s < THR → 11
  - s ≥ THR → 10
- Resync:
  - sym_start arriving while the phase counter ≠ 0 discards the partial accumulation; acc restarts from this sample's product.
  - No out_valid is produced for the discarded partial symbol.
  - sym_start with the counter already at 0 has no side effect.
- No backpressure: the consumer must take the outputs on the out_valid pulse.

## Timing
- Reset values: acc_out=0, i_level=00, out_valid=0, err=0, phase=0, acc=0, product register=0, product-valid=0.
- Pipeline is 2 stages:
  - Edge E: sample accepted, product registered.
  - Edge E+1: product accumulated; on phase 15, acc_out, i_level and out_valid are registered.
  - out_valid is therefore high in the cycle after edge E+1.
- Throughput is one sample per clock. Gaps in sample_valid stall both stages; no product is lost or double-counted.
- out_valid is high for exactly one cycle per completed symbol, at most once every 16 accepted samples.
- acc_out and i_level hold their values between pulses.
- Reset mid-symbol: everything returns to the reset values immediately (asynchronous); the partial symbol is lost.
- Back-to-back symbols: the dump and the accumulation of the next symbol's phase-0 product never collide, because the clear happens on the dump edge.

## Configuration
- DEMOD_COS_ERR_EN defined:
  - err pulses together with out_valid when |acc_out| ≥ 2·THR (overrange).
  - err also pulses one cycle after a resync that discarded a partial symbol (sym_start with phase ≠ 0).
- Not defined: err is tied to 0.
- All other behaviour is identical in both builds.

## Test plan
- 16 samples of A·cos(2πk/16) with A=1024, sym_start on k=0 → one out_valid 2 edges after sample 15; acc_out in 8192±64; i_level=11.
- Repeat with A=3072, -1024, -3072 back-to-back with no gaps → four out_valid pulses 16 cycles apart; i_level 10, 01, 00.
- Constant sample_in=1000 for 16 samples → acc_out=0 exactly; i_level=11.
- A=1024 symbol with sample_valid deasserted 3 random cycles mid-symbol → same acc_out as the gapless run; out_valid delayed by 3 cycles.
- sym_start asserted at phase 7 of a symbol, then a full A=-1024 symbol → no out_valid for the partial symbol, next result i_level=01; err pulses once with DEMOD_COS_ERR_EN defined, stays 0 without it.
- rst_n low at phase 9, released, then a full A=3072 symbol → all outputs 0 during reset; the first out_valid comes after 16 new samples with i_level=10.
